imu_spi_responder: RTL and testbench
====================================

IMU_SPI_RESPONDER -- requirements
Module: imu_spi_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for sck/ss_n/mosi.
REQ-002 SHALL have parameter ADDR_BITS, default 7, register address width.
REQ-003 clk  input  1  system clock; all logic in this single domain.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 sck  input  1  SPI clock from master, mode 0 (idle low; sample rising edge, shift falling edge).
REQ-006 ss_n  input  1  slave select, active-low; frame boundary.
REQ-007 mosi  input  1  master-to-slave data, MSB first.
REQ-008 miso  output  1  slave-to-master data, MSB first.
REQ-009 reg_addr  output  ADDR_BITS  current register address.
REQ-010 reg_wdata  output  8  write data, valid with reg_we.
REQ-011 reg_we  output  1  one-cycle write strobe.
REQ-012 reg_re  output  1  one-cycle read request.
REQ-013 reg_rdata  input  8  read data, valid the cycle after reg_re.
REQ-014 busy  output  1  high while a frame is active (state != IDLE).
REQ-015 frame_done  output  1  one-cycle pulse at ss_n deassertion after at least one complete byte.

Function
REQ-016 sck, ss_n and mosi SHALL pass through SYNC_STAGES flops; sck edges SHALL be detected from the synchronized value.
REQ-017 Legal operation SHALL require an sck half-period of at least 6 clk cycles.
REQ-018 States SHALL be IDLE, CMD, DATA, WAIT_DESEL.
REQ-019 IDLE -> CMD on synchronized ss_n falling; bit counter cleared.
REQ-020 In CMD, 8 bits sampled on sck rising: bit7 = R/nW, bits 6:0 = address; the 8th rising edge latches reg_addr and moves to DATA.
REQ-021 If R/nW=1, reg_re SHALL pulse the cycle after the 8th CMD rising edge, and reg_rdata SHALL be loaded into the TX shift register one cycle later.
REQ-022 miso SHALL update only on sck falling edges, presenting TX MSB on the first falling edge after the load.
REQ-023 miso SHALL be 0 during CMD and during write frames, and 0 while IDLE.
REQ-024 Write: each 8 DATA bits complete -> reg_we pulse for 1 cycle with the current reg_addr/reg_wdata, then reg_addr+1.
REQ-025 Read: each 8 DATA bits complete -> reg_addr+1, reg_re pulse, TX reload as in REQ-021 (burst auto-increment).
REQ-026 Address increment SHALL wrap 2^ADDR_BITS-1 -> 0.
REQ-027 ss_n rising in any state SHALL return to IDLE within 1 cycle of detection; a partial byte SHALL be discarded with no reg_we.
REQ-028 Simultaneous ss_n rising and 8th-bit rising edge SHALL complete the byte (strobe issued) before returning to IDLE.
REQ-029 Bits received while ss_n is high SHALL be ignored.

Reset
REQ-030 rst SHALL force: state WAIT_DESEL, miso=0, reg_we=0, reg_re=0, frame_done=0, reg_addr=0, reg_wdata=0, busy=0, counters 0, synchronizers to ss_n=1, sck=0.
REQ-031 WAIT_DESEL SHALL go to IDLE only after ss_n is seen high; reset asserted mid-frame SHALL abort the frame and ignore its remainder.

Structure
REQ-032 Mode constants, the R/nW bit position and state encodings SHALL live in the shared imu_spi_defs include, also used by the IMU master sequencer.
REQ-033 One sub-module, spi_edge_sync, SHALL provide the synchronizer plus rise/fall detection, instantiated for sck and ss_n.

Verification
REQ-034 Write frame 0x6B,0x80 -> one reg_we with reg_addr=0x6B and reg_wdata=0x80; frame_done 1 pulse.
REQ-035 Read frame 0xBC + 1 dummy byte, reg_rdata=0x5A -> master receives 0x5A; reg_re once with addr 0x3C.
REQ-036 Burst read from 0x3B, 6 dummy bytes -> reg_re addresses 0x3B..0x40 in order; bytes match the model.
REQ-037 Write burst from 0x7F, 2 bytes -> reg_we at 0x7F then 0x00 (wrap).
REQ-038 ss_n raised after 5 bits of a write data byte -> no reg_we; next frame decodes correctly.
REQ-039 rst mid read burst, ss_n held low -> no strobes until ss_n high, then low; the new frame works.

Source files
------------

// File: rtl/imu_spi_responder_pkg.sv
// Shared IMU SPI definitions: bus mode, command byte layout and responder
// state encodings. The IMU master sequencer builds its frames from the same
// definitions.
package imu_spi_responder_pkg;

   localparam int unsigned BYTE_BITS     = 8;
   localparam int unsigned CMD_ADDR_BITS = 7;

   // SPI mode 0: sck idles low, data sampled on rising, shifted on falling
   localparam logic SPI_CPOL = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_CMD        = 2'd1,
      ST_DATA       = 2'd2,
      ST_WAIT_DESEL = 2'd3
   } spi_state_e;

   // Command byte, MSB first on the wire: R/nW in bit 7, address in bits 6:0
   typedef struct packed {
      logic                     rnw;
      logic [CMD_ADDR_BITS-1:0] addr;
   } spi_cmd_t;

endpackage

// File: rtl/imu_spi_responder_spi_edge_sync.sv
// Multi-flop synchronizer for one asynchronous input, plus rise/fall
// detection on the synchronized level.
//   clk, rst : system clock, synchronous active-high reset
//   din      : asynchronous input
//   sync     : synchronized level (registered)
//   rise_c   : one-cycle pulse on a synchronized 0->1 transition
//   fall_c   : one-cycle pulse on a synchronized 1->0 transition
module spi_edge_sync #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic        RESET_VAL   = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic sync,
   output logic rise_c,
   output logic fall_c
);

   logic [SYNC_STAGES-1:0] pipe;
   logic                   prev;

   // Synchronizer chain plus one history flop for edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         pipe <= {SYNC_STAGES{RESET_VAL}};
         prev <= RESET_VAL;
      end else begin
         pipe[0] <= din;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            pipe[i] <= pipe[i-1];
         end
         prev <= pipe[SYNC_STAGES-1];
      end
   end

   assign sync   = pipe[SYNC_STAGES-1];
   assign rise_c = sync & ~prev;
   assign fall_c = ~sync & prev;

endmodule

// File: rtl/imu_spi_responder.sv
// SPI mode-0 register-access responder for the IMU. A frame is one command
// byte (R/nW + address) followed by data bytes with address auto-increment.
//   clk, rst          : system clock, synchronous active-high reset
//   sck, ss_n, mosi   : asynchronous SPI inputs from the master
//   miso              : serial read data, MSB first
//   reg_addr          : current register address
//   reg_wdata, reg_we : write data and one-cycle write strobe
//   reg_re            : one-cycle read request; reg_rdata is valid one cycle later
//   busy              : a frame is in progress
//   frame_done        : pulse when ss_n deasserts after at least one whole byte
module imu_spi_responder
   import imu_spi_responder_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned ADDR_BITS   = 7
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 sck,
   input  logic                 ss_n,
   input  logic                 mosi,
   output logic                 miso,
   output logic [ADDR_BITS-1:0] reg_addr,
   output logic [7:0]           reg_wdata,
   output logic                 reg_we,
   output logic                 reg_re,
   input  logic [7:0]           reg_rdata,
   output logic                 busy,
   output logic                 frame_done
);

   localparam int unsigned SETTLE_W = $clog2(SYNC_STAGES + 2);
   localparam int unsigned CNT_W    = $clog2(BYTE_BITS);

   logic sck_s, sck_rise_c, sck_fall_c;
   logic ss_s, ss_rise_c, ss_fall_c;
   logic [SYNC_STAGES-1:0] mosi_pipe;
   logic mosi_s;

   spi_state_e           state;
   logic [CNT_W-1:0]     bit_cnt;
   logic [BYTE_BITS-2:0] rx_sr;
   logic [BYTE_BITS-1:0] rx_byte_c;
   logic [BYTE_BITS-1:0] tx_sr;
   spi_cmd_t             cmd_c;
   logic                 rnw;
   logic                 load_pend;
   logic                 byte_seen;
   logic                 byte_end_c;
   logic [SETTLE_W-1:0]  settle_cnt;

   spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
      .clk(clk), .rst(rst), .din(sck),
      .sync(sck_s), .rise_c(sck_rise_c), .fall_c(sck_fall_c)
   );

   spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
      .clk(clk), .rst(rst), .din(ss_n),
      .sync(ss_s), .rise_c(ss_rise_c), .fall_c(ss_fall_c)
   );

   // mosi gets the same depth as sck so the sampled bit lines up with the edge
   always_ff @(posedge clk) begin
      if (rst) begin
         mosi_pipe <= '0;
      end else begin
         mosi_pipe[0] <= mosi;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            mosi_pipe[i] <= mosi_pipe[i-1];
         end
      end
   end
   assign mosi_s = mosi_pipe[SYNC_STAGES-1];

   assign rx_byte_c  = {rx_sr, mosi_s};
   assign cmd_c      = spi_cmd_t'(rx_byte_c);
   assign byte_end_c = sck_rise_c && (bit_cnt == CNT_W'(BYTE_BITS - 1));

   // Frame FSM with registered strobes, address and shift registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_WAIT_DESEL;
         miso       <= 1'b0;
         reg_we     <= 1'b0;
         reg_re     <= 1'b0;
         frame_done <= 1'b0;
         reg_addr   <= '0;
         reg_wdata  <= '0;
         busy       <= 1'b0;
         bit_cnt    <= '0;
         rx_sr      <= '0;
         tx_sr      <= '0;
         rnw        <= 1'b0;
         load_pend  <= 1'b0;
         byte_seen  <= 1'b0;
         settle_cnt <= '0;
      end else begin
         reg_we     <= 1'b0;
         reg_re     <= 1'b0;
         frame_done <= 1'b0;

         // Read data arrives the cycle after reg_re; capture it the cycle after that
         load_pend <= reg_re;
         if (load_pend) tx_sr <= reg_rdata;

         // Post-write increment, one cycle after the strobe
         if (reg_we) reg_addr <= reg_addr + ADDR_BITS'(1);

         case (state)
            // The ss_n synchronizer resets high, so a level of 1 only counts once
            // it has outlived the reset contents of the chain.
            ST_WAIT_DESEL: begin
               if (ss_rise_c || (ss_s && (settle_cnt == SETTLE_W'(SYNC_STAGES)))) begin
                  state      <= ST_IDLE;
                  settle_cnt <= '0;
               end else if (ss_s) begin
                  settle_cnt <= settle_cnt + SETTLE_W'(1);
               end else begin
                  settle_cnt <= '0;
               end
            end

            ST_IDLE: begin
               if (ss_fall_c && (sck_s == SPI_CPOL)) begin
                  state     <= ST_CMD;
                  busy      <= 1'b1;
                  bit_cnt   <= '0;
                  byte_seen <= 1'b0;
                  rnw       <= 1'b0;
               end
            end

            ST_CMD: begin
               if (sck_rise_c) begin
                  rx_sr   <= rx_byte_c[BYTE_BITS-2:0];
                  bit_cnt <= bit_cnt + CNT_W'(1);
                  if (byte_end_c) begin
                     state     <= ST_DATA;
                     rnw       <= cmd_c.rnw;
                     reg_addr  <= ADDR_BITS'(cmd_c.addr);
                     reg_re    <= cmd_c.rnw;
                     byte_seen <= 1'b1;
                  end
               end
            end

            ST_DATA: begin
               if (sck_rise_c) begin
                  rx_sr   <= rx_byte_c[BYTE_BITS-2:0];
                  bit_cnt <= bit_cnt + CNT_W'(1);
                  if (byte_end_c) begin
                     byte_seen <= 1'b1;
                     if (rnw) begin
                        // Prefetch the next register for a burst read
                        reg_addr <= reg_addr + ADDR_BITS'(1);
                        reg_re   <= 1'b1;
                     end else begin
                        reg_we    <= 1'b1;
                        reg_wdata <= rx_byte_c;
                     end
                  end
               end
               if (sck_fall_c) begin
                  miso <= rnw & tx_sr[BYTE_BITS-1];
                  if (rnw) tx_sr <= {tx_sr[BYTE_BITS-2:0], 1'b0};
               end
            end

            default: state <= ST_WAIT_DESEL;
         endcase

         // Deselect ends the frame; a byte finishing on the same cycle still counts
         if (ss_rise_c && ((state == ST_CMD) || (state == ST_DATA))) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            miso       <= 1'b0;
            frame_done <= byte_seen | byte_end_c;
         end
      end
   end

endmodule

// File: tb/tb_imu_spi_responder.sv
`timescale 1ns/1ps
// Directed bench for imu_spi_responder: a mode-0 SPI master, a register file
// model answering reg_re, and strobe logs checked per scenario.
module tb_imu_spi_responder;

   localparam int HALF = 8;  // sck half-period in clk cycles

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sck = 1'b0;
   logic       ss_n = 1'b1;
   logic       mosi = 1'b0;
   logic       miso;
   logic [6:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       reg_we;
   logic       reg_re;
   logic [7:0] reg_rdata = 8'h00;
   logic       busy;
   logic       frame_done;

   int checks = 0;
   int errors = 0;

   logic [7:0] mem [128];
   logic [6:0] we_addr_q [$];
   logic [7:0] we_data_q [$];
   logic [6:0] re_addr_q [$];
   int         fd_cnt = 0;
   logic       miso_seen = 1'b0;

   imu_spi_responder #(.SYNC_STAGES(2), .ADDR_BITS(7)) dut (
      .clk(clk), .rst(rst), .sck(sck), .ss_n(ss_n), .mosi(mosi), .miso(miso),
      .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
      .reg_rdata(reg_rdata), .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // Register file: answers a read request on the following cycle
   always @(posedge clk) begin
      reg_rdata <= reg_re ? mem[reg_addr] : 8'h00;
   end

   // Strobe logger, sampled away from the active edge
   always @(negedge clk) begin
      if (reg_we) begin
         we_addr_q.push_back(reg_addr);
         we_data_q.push_back(reg_wdata);
      end
      if (reg_re) re_addr_q.push_back(reg_addr);
      if (frame_done) fd_cnt++;
      if (miso === 1'b1) miso_seen = 1'b1;
   end

   task automatic clk_wait(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      we_addr_q.delete();
      we_data_q.delete();
      re_addr_q.delete();
      fd_cnt    = 0;
      miso_seen = 1'b0;
   endtask

   // Shift n bits MSB first; rx collects miso sampled at each rising edge
   task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 0; i < n; i++) begin
         mosi = tx[3'(7 - i)];
         clk_wait(HALF);
         sck = 1'b1;
         rx  = {rx[6:0], miso};
         clk_wait(HALF);
         sck = 1'b0;
      end
   endtask

   task automatic frame_start();
      ss_n = 1'b0;
      clk_wait(HALF);
   endtask

   task automatic frame_end();
      clk_wait(HALF);
      ss_n = 1'b1;
      clk_wait(3 * HALF);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clk_wait(3);
      checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b expected 0", miso); end
      checks++; if ({reg_we, reg_re, frame_done} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %b expected 000", {reg_we, reg_re, frame_done}); end
      checks++; if (reg_addr !== 7'h00) begin errors++; $display("FAIL reset_addr: got %h expected 00", reg_addr); end
      checks++; if (reg_wdata !== 8'h00) begin errors++; $display("FAIL reset_wdata: got %h expected 00", reg_wdata); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      rst = 1'b0;
      clk_wait(10);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
   endtask

   task automatic test_write();
      logic [7:0] rx;
      clear_logs();
      frame_start();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy: got %b expected 1", busy); end
      spi_bits(8'h6B, 8, rx);
      spi_bits(8'h80, 8, rx);
      frame_end();
      checks++; if (we_addr_q.size() != 1) begin errors++; $display("FAIL write_we_count: got %0d expected 1", we_addr_q.size()); end
      checks++; if (we_addr_q[0] !== 7'h6B) begin errors++; $display("FAIL write_addr: got %h expected 6b", we_addr_q[0]); end
      checks++; if (we_data_q[0] !== 8'h80) begin errors++; $display("FAIL write_data: got %h expected 80", we_data_q[0]); end
      checks++; if (fd_cnt != 1) begin errors++; $display("FAIL write_frame_done: got %0d expected 1", fd_cnt); end
      checks++; if (re_addr_q.size() != 0) begin errors++; $display("FAIL write_re_count: got %0d expected 0", re_addr_q.size()); end
      checks++; if (miso_seen !== 1'b0) begin errors++; $display("FAIL write_miso: got %b expected 0", miso_seen); end
   endtask

   task automatic test_read();
      logic [7:0] rx;
      int n3c;
      clear_logs();
      mem[8'h3C] = 8'h5A;
      mem[8'h3D] = 8'hFF;
      frame_start();
      spi_bits(8'hBC, 8, rx);
      spi_bits(8'h00, 8, rx);
      frame_end();
      n3c = 0;
      foreach (re_addr_q[i]) if (re_addr_q[i] === 7'h3C) n3c++;
      checks++; if (rx !== 8'h5A) begin errors++; $display("FAIL read_data: got %h expected 5a", rx); end
      checks++; if (n3c != 1) begin errors++; $display("FAIL read_re_3c: got %0d expected 1", n3c); end
      checks++; if (re_addr_q[0] !== 7'h3C) begin errors++; $display("FAIL read_first_re: got %h expected 3c", re_addr_q[0]); end
      checks++; if (re_addr_q.size() != 2) begin errors++; $display("FAIL read_re_total: got %0d expected 2", re_addr_q.size()); end
      checks++; if (we_addr_q.size() != 0) begin errors++; $display("FAIL read_we_count: got %0d expected 0", we_addr_q.size()); end
      checks++; if (fd_cnt != 1) begin errors++; $display("FAIL read_frame_done: got %0d expected 1", fd_cnt); end
   endtask

   task automatic test_burst_read();
      logic [7:0] rx;
      logic [7:0] exp_b [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      clear_logs();
      for (int k = 0; k < 6; k++) mem[59 + k] = exp_b[k];
      mem[65] = 8'h00;
      frame_start();
      spi_bits(8'hBB, 8, rx);
      for (int k = 0; k < 6; k++) begin
         spi_bits(8'h00, 8, rx);
         checks++; if (rx !== exp_b[k]) begin errors++; $display("FAIL burst_byte%0d: got %h expected %h", k, rx, exp_b[k]); end
      end
      frame_end();
      for (int k = 0; k < 6; k++) begin
         checks++; if (re_addr_q[k] !== 7'(59 + k)) begin errors++; $display("FAIL burst_re%0d: got %h expected %h", k, re_addr_q[k], 7'(59 + k)); end
      end
      checks++; if (re_addr_q.size() != 7) begin errors++; $display("FAIL burst_re_total: got %0d expected 7", re_addr_q.size()); end
   endtask

   task automatic test_write_wrap();
      logic [7:0] rx;
      clear_logs();
      frame_start();
      spi_bits(8'h7F, 8, rx);
      spi_bits(8'hA1, 8, rx);
      spi_bits(8'hB2, 8, rx);
      frame_end();
      checks++; if (we_addr_q.size() != 2) begin errors++; $display("FAIL wrap_we_count: got %0d expected 2", we_addr_q.size()); end
      checks++; if ({we_addr_q[0], we_data_q[0]} !== {7'h7F, 8'hA1}) begin errors++; $display("FAIL wrap_first: got %h/%h expected 7f/a1", we_addr_q[0], we_data_q[0]); end
      checks++; if ({we_addr_q[1], we_data_q[1]} !== {7'h00, 8'hB2}) begin errors++; $display("FAIL wrap_second: got %h/%h expected 00/b2", we_addr_q[1], we_data_q[1]); end
   endtask

   task automatic test_partial();
      logic [7:0] rx;
      clear_logs();
      frame_start();
      spi_bits(8'h10, 8, rx);
      spi_bits(8'hFF, 5, rx);
      frame_end();
      checks++; if (we_addr_q.size() != 0) begin errors++; $display("FAIL partial_we: got %0d expected 0", we_addr_q.size()); end
      checks++; if (fd_cnt != 1) begin errors++; $display("FAIL partial_frame_done: got %0d expected 1", fd_cnt); end
      clear_logs();
      frame_start();
      spi_bits(8'h12, 8, rx);
      spi_bits(8'h34, 8, rx);
      frame_end();
      checks++; if (we_addr_q.size() != 1) begin errors++; $display("FAIL after_partial_count: got %0d expected 1", we_addr_q.size()); end
      checks++; if ({we_addr_q[0], we_data_q[0]} !== {7'h12, 8'h34}) begin errors++; $display("FAIL after_partial_we: got %h/%h expected 12/34", we_addr_q[0], we_data_q[0]); end
   endtask

   task automatic test_simultaneous();
      logic [7:0] rx;
      clear_logs();
      frame_start();
      spi_bits(8'h20, 8, rx);
      spi_bits(8'hC7, 7, rx);
      mosi = 1'b1;
      clk_wait(HALF);
      sck  = 1'b1;
      ss_n = 1'b1;
      clk_wait(HALF);
      sck  = 1'b0;
      clk_wait(3 * HALF);
      checks++; if (we_addr_q.size() != 1) begin errors++; $display("FAIL simul_we_count: got %0d expected 1", we_addr_q.size()); end
      checks++; if ({we_addr_q[0], we_data_q[0]} !== {7'h20, 8'hC7}) begin errors++; $display("FAIL simul_we: got %h/%h expected 20/c7", we_addr_q[0], we_data_q[0]); end
      checks++; if (fd_cnt != 1) begin errors++; $display("FAIL simul_frame_done: got %0d expected 1", fd_cnt); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] rx;
      clear_logs();
      frame_start();
      spi_bits(8'hBB, 8, rx);
      spi_bits(8'h00, 8, rx);
      spi_bits(8'h00, 3, rx);
      rst = 1'b1;
      clk_wait(2);
      rst = 1'b0;
      clear_logs();
      checks++; if (reg_addr !== 7'h00) begin errors++; $display("FAIL midrst_addr: got %h expected 00", reg_addr); end
      spi_bits(8'hFF, 8, rx);
      spi_bits(8'hA5, 4, rx);
      clk_wait(HALF);
      checks++; if ((we_addr_q.size() + re_addr_q.size()) != 0) begin errors++; $display("FAIL midrst_strobes: got %0d expected 0", we_addr_q.size() + re_addr_q.size()); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
      ss_n = 1'b1;
      clk_wait(3 * HALF);
      checks++; if (fd_cnt != 0) begin errors++; $display("FAIL midrst_frame_done: got %0d expected 0", fd_cnt); end
      frame_start();
      spi_bits(8'h05, 8, rx);
      spi_bits(8'h99, 8, rx);
      frame_end();
      checks++; if (we_addr_q.size() != 1) begin errors++; $display("FAIL midrst_new_count: got %0d expected 1", we_addr_q.size()); end
      checks++; if ({we_addr_q[0], we_data_q[0]} !== {7'h05, 8'h99}) begin errors++; $display("FAIL midrst_new_we: got %h/%h expected 05/99", we_addr_q[0], we_data_q[0]); end
      checks++; if (fd_cnt != 1) begin errors++; $display("FAIL midrst_new_frame_done: got %0d expected 1", fd_cnt); end
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 8'h00;
      test_reset();
      test_write();
      test_read();
      test_burst_read();
      test_write_wrap();
      test_partial();
      test_simultaneous();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
